// File: rtl/fc_stream_decoder.sv
// fc_stream_decoder: SEC/DED Hamming(8,4) decode of the fast control stream, strobe regeneration, BCR-locked bx counter and error statistics.
// Latency: 2 clk_bx cycles from fc_stream_enc to command strobes, bxid, locked and counter updates.
// Backpressure: none; one encoded word is consumed every bx. Optional macro FC_RX_L1A_TAG_EN adds l1a_bxid / l1a_tag_valid.
module fc_stream_decoder #(
   parameter int LOCK_COUNT   = 4,
   parameter int UNLOCK_COUNT = 3,
   parameter int CNT_W        = 16
) (
   input  logic             clk_bx,
   input  logic             reset,
   input  logic [15:0]      fc_stream_enc,
   input  logic [11:0]      orb_length,
   input  logic             clear_counters,
   output logic             bcr,
   output logic             l1a,
   output logic             link_reset,
   output logic             buffer_clear,
   output logic             calib_pulse,
   output logic [11:0]      bxid,
   output logic             locked,
   output logic [CNT_W-1:0] sec_count,
   output logic [CNT_W-1:0] ded_count,
   output logic [CNT_W-1:0] misalign_count,
`ifdef FC_RX_L1A_TAG_EN
   output logic [11:0]      l1a_bxid,
   output logic             l1a_tag_valid,
`endif
   output logic [31:0]      l1a_count
);

   localparam int GW = $clog2(LOCK_COUNT + 1);
   localparam int BW = $clog2(UNLOCK_COUNT + 1);

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_ACQUIRE  = 2'd1,
      ST_LOCKED   = 2'd2
   } state_t;

   // Returns {sec, ded, d[3:0]} for one code byte {p0,d3,d2,d1,p3,d0,p2,p1}.
   function automatic logic [5:0] dec_nibble(input logic [7:0] code);
      logic [2:0] syn;
      logic       par_err;
      logic       flip;
      logic [3:0] d;
      syn[0]  = code[0] ^ code[2] ^ code[4] ^ code[6];
      syn[1]  = code[1] ^ code[2] ^ code[5] ^ code[6];
      syn[2]  = code[3] ^ code[4] ^ code[5] ^ code[6];
      par_err = ^code;
      // Only a data position (3,5,6,7) needs an actual correction of the payload.
      flip    = par_err && (syn != 3'd0);
      d[0]    = code[2] ^ (flip && (syn == 3'd3));
      d[1]    = code[4] ^ (flip && (syn == 3'd5));
      d[2]    = code[5] ^ (flip && (syn == 3'd6));
      d[3]    = code[6] ^ (flip && (syn == 3'd7));
      return {par_err, (!par_err) && (syn != 3'd0), d};
   endfunction

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] val, input logic [1:0] inc);
      logic [CNT_W:0] sum;
      sum = {1'b0, val} + {{(CNT_W-1){1'b0}}, inc};
      return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   endfunction

   logic [15:0]  enc_q;
   logic [5:0]   dec_lo, dec_hi;
   logic [7:0]   data;
   logic         any_ded;
   logic         cmd_bcr, cmd_l1a, cmd_lrst, cmd_bclr, cmd_calib;
   logic [1:0]   sec_inc, ded_inc;
   logic         unused_bits;

   logic [12:0]  bx_plus;
   logic         bx_wrap;
   logic [11:0]  bx_free, bxid_nxt;
   logic         bx_reload;
   logic         misalign_evt;

   state_t       state, state_nxt;
   logic [GW-1:0] good_cnt, good_nxt;
   logic [BW-1:0] bad_cnt, bad_nxt;

   // Stage 1: capture the raw encoded word.
   always_ff @(posedge clk_bx or posedge reset) begin
      if (reset) enc_q <= '0;
      else       enc_q <= fc_stream_enc;
   end

   assign dec_lo    = dec_nibble(enc_q[7:0]);
   assign dec_hi    = dec_nibble(enc_q[15:8]);
   assign data      = {dec_hi[3:0], dec_lo[3:0]};
   assign any_ded   = dec_lo[4] | dec_hi[4];
   assign sec_inc   = {1'b0, dec_lo[5]} + {1'b0, dec_hi[5]};
   assign ded_inc   = {1'b0, dec_lo[4]} + {1'b0, dec_hi[4]};

   // An uncorrectable nibble poisons the whole word, including the BCR used for alignment.
   assign cmd_bcr   = data[0] & ~any_ded;
   assign cmd_l1a   = data[1] & ~any_ded;
   assign cmd_lrst  = data[2] & ~any_ded;
   assign cmd_bclr  = data[3] & ~any_ded;
   assign cmd_calib = data[5] & ~any_ded;
   assign unused_bits = ^{data[7:6], data[4]};

   // Free-running bx: wrap after orb_length-1, and also recover from any out-of-range value.
   assign bx_plus  = {1'b0, bxid} + 13'd1;
   assign bx_wrap  = bx_plus >= {1'b0, orb_length};
   assign bx_free  = bx_wrap ? 12'd0 : bx_plus[11:0];
   assign bxid_nxt = bx_reload ? 12'd0 : bx_free;

   // Lock tracking: next state, alignment counters, bx realignment and misalignment events.
   always_comb begin
      state_nxt    = state;
      good_nxt     = good_cnt;
      bad_nxt      = bad_cnt;
      bx_reload    = 1'b0;
      misalign_evt = 1'b0;
      case (state)
         ST_UNLOCKED: begin
            if (cmd_bcr) begin
               state_nxt = ST_ACQUIRE;
               good_nxt  = GW'(1);
               bx_reload = 1'b1;
            end
         end
         ST_ACQUIRE: begin
            if (cmd_bcr) begin
               if (bx_wrap) begin
                  good_nxt = good_cnt + GW'(1);
                  if (good_nxt == GW'(LOCK_COUNT)) begin
                     state_nxt = ST_LOCKED;
                     bad_nxt   = '0;
                  end
               end else begin
                  good_nxt  = GW'(1);
                  bx_reload = 1'b1;
               end
            end else if (bx_wrap) begin
               state_nxt = ST_UNLOCKED;
            end
         end
         ST_LOCKED: begin
            if (cmd_bcr && bx_wrap) begin
               bad_nxt = '0;
            end else if (cmd_bcr || bx_wrap) begin
               misalign_evt = 1'b1;
               bad_nxt      = bad_cnt + BW'(1);
               if (bad_nxt == BW'(UNLOCK_COUNT)) state_nxt = ST_UNLOCKED;
            end
         end
         default: state_nxt = ST_UNLOCKED;
      endcase
   end

   // Lock state and alignment counters register.
   always_ff @(posedge clk_bx or posedge reset) begin
      if (reset) begin
         state    <= ST_UNLOCKED;
         good_cnt <= '0;
         bad_cnt  <= '0;
      end else begin
         state    <= state_nxt;
         good_cnt <= good_nxt;
         bad_cnt  <= bad_nxt;
      end
   end

   assign locked = (state == ST_LOCKED);

   // Stage 2: command strobes and bx counter.
   always_ff @(posedge clk_bx or posedge reset) begin
      if (reset) begin
         bcr          <= 1'b0;
         l1a          <= 1'b0;
         link_reset   <= 1'b0;
         buffer_clear <= 1'b0;
         calib_pulse  <= 1'b0;
         bxid         <= '0;
      end else begin
         bcr          <= cmd_bcr;
         l1a          <= cmd_l1a;
         link_reset   <= cmd_lrst;
         buffer_clear <= cmd_bclr;
         calib_pulse  <= cmd_calib;
         bxid         <= bxid_nxt;
      end
   end

   // Statistics: saturating error counters, wrapping L1A counter, clear wins over increment.
   always_ff @(posedge clk_bx or posedge reset) begin
      if (reset) begin
         sec_count      <= '0;
         ded_count      <= '0;
         misalign_count <= '0;
         l1a_count      <= '0;
      end else if (clear_counters) begin
         sec_count      <= '0;
         ded_count      <= '0;
         misalign_count <= '0;
         l1a_count      <= '0;
      end else begin
         sec_count      <= sat_add(sec_count, sec_inc);
         ded_count      <= sat_add(ded_count, ded_inc);
         misalign_count <= sat_add(misalign_count, {1'b0, misalign_evt});
         l1a_count      <= l1a_count + {31'd0, cmd_l1a};
      end
   end

`ifdef FC_RX_L1A_TAG_EN
   // L1A tagging: capture the bx presented alongside each l1a strobe.
   always_ff @(posedge clk_bx or posedge reset) begin
      if (reset) begin
         l1a_bxid      <= '0;
         l1a_tag_valid <= 1'b0;
      end else begin
         l1a_tag_valid <= cmd_l1a;
         if (cmd_l1a) l1a_bxid <= bxid_nxt;
      end
   end
`endif

endmodule

// File: doc/fc_stream_decoder.md
Name: fc_stream_decoder

Overview:
- Receive-side counterpart of the fast control encoder.
- Takes the 16-bit Hamming(8,4)-encoded fast control stream, one word per clk_bx cycle, and decodes each nibble with single-error correction and double-error detection.
- Regenerates the command strobes (BCR, L1A, link reset, buffer clear, calib pulse) and a local bunch-crossing counter aligned to BCR, with lock tracking and error statistics.
- Sits in front-end / downstream firmware at the fast control link input.

Parameters:
- LOCK_COUNT, 4: consecutive aligned BCRs required to declare lock.
- UNLOCK_COUNT, 3: consecutive bad BCR positions (misaligned or missing) that drop lock.
- CNT_W, 16: width of the saturating error counters.

Ports:
- clk_bx  input  1  bunch-crossing clock (40 MHz).
- reset  input  1  asynchronous, active-high reset.
- fc_stream_enc  input  16  encoded word; [7:0] low nibble code, [15:8] high nibble code.
- orb_length  input  12  orbit length in bx. Quasi-static; may change only while unlocked.
- clear_counters  input  1  synchronous clear of all statistics counters.
- bcr  output  1  decoded bunch-count reset strobe (bit 0).
- l1a  output  1  decoded L1A strobe (bit 1).
- link_reset  output  1  decoded link reset strobe (bit 2).
- buffer_clear  output  1  decoded buffer clear strobe (bit 3).
- calib_pulse  output  1  decoded calib pulse level (bit 5).
- bxid  output  12  local bx counter.
- locked  output  1  high in LOCKED state.
- sec_count  output  CNT_W  corrected single-bit errors, per nibble.
- ded_count  output  CNT_W  uncorrectable double-bit errors, per nibble.
- misalign_count  output  CNT_W  bad BCR positions seen while LOCKED.
- l1a_count  output  32  decoded L1As, wrapping.

Behaviour:
- Reset:
  - All outputs and counters go to 0.
  - State goes to UNLOCKED.
- Code definition, per nibble, data d[3:0]:
  - p1=d0^d1^d3, p2=d0^d2^d3, p3=d1^d2^d3, p0 = XOR of the seven other bits.
  - Code bit order [7:0] = {p0,d3,d2,d1,p3,d0,p2,p1}.
- Decode per nibble:
  - syndrome s = {p3,p2,p1} check.
  - Overall parity error with s!=0: flip the bit at position s (SEC).
  - Overall parity error with s==0: p0 is in error; data is good (SEC).
  - s!=0 with overall parity good: DED.
- Pipeline and latency:
  - Stage 1 registers fc_stream_enc.
  - Stage 2 registers the decoded word and the strobes.
  - Latency is 2 clk_bx cycles from input word to strobe.
- Error handling:
  - Any DED in a word forces all five command outputs to 0 for that word.
  - A DED word does not count as a BCR.
  - sec_count and ded_count increment by 1 or 2 per word (one per affected nibble).
  - Counters saturate at all-ones.
  - clear_counters has priority over a simultaneous increment.
  - Bits 4, 6 and 7 are ignored.
- bxid:
  - Advances by 1 every cycle and wraps to 0 after orb_length-1.
  - If bxid >= orb_length, the next value is 0.
  - In UNLOCKED and ACQUIRE, a decoded BCR forces bxid=0 in the same cycle the bcr output is high.
  - In LOCKED, bxid is never reloaded.
- Aligned BCR: a BCR arriving on the cycle where the free-running bxid wraps to 0.
- State machine:
  - UNLOCKED → ACQUIRE on the first decoded BCR; the good count is set to 1.
  - ACQUIRE, aligned BCR: good count +1. When it reaches LOCK_COUNT, go to LOCKED.
  - ACQUIRE, misaligned BCR: good count restarts at 1 and bxid is realigned.
  - ACQUIRE, no BCR at the wrap point: go to UNLOCKED.
  - LOCKED, misaligned BCR or no BCR at the wrap point: misalign_count +1 and bad count +1. When bad count reaches UNLOCK_COUNT, go to UNLOCKED.
  - LOCKED, aligned BCR: bad count cleared.
- calib_pulse: follows decoded bit 5 directly (multi-cycle level preserved). It is not re-synthesised.
- Mid-operation reset: pipeline is flushed and no strobe is emitted during reset.

Optional Feature:
- Macro: FC_RX_L1A_TAG_EN.
- When defined:
  - Adds output l1a_bxid[11:0] and output l1a_tag_valid.
  - On each decoded l1a, l1a_bxid captures bxid of that same cycle.
  - l1a_tag_valid pulses for one cycle, aligned with l1a.
  - l1a_bxid holds its value between L1As; reset value 0.
- When undefined: neither port exists, and logic and timing are otherwise identical.

Test Plan:
- Clean stream, orb_length=45, BCR every 45 words, reset released → locked rises the cycle of the 4th BCR; bxid=0 on each bcr; misalign_count=0.
- Locked; inject L1A word 0x02 (fc_stream_enc=encode(0x2)) at bxid 10 → l1a high exactly 2 cycles after input, for 1 cycle; l1a_count=1; with FC_RX_L1A_TAG_EN, l1a_bxid=10.
- Flip one bit in each nibble of a buffer_clear word → buffer_clear asserted; sec_count +2; ded_count unchanged.
- Flip two bits in the low nibble of a BCR word while locked → no bcr output; ded_count +1; misalign_count +1; locked stays high. Three consecutive such words → locked falls.
- Locked at orb_length=45, then a BCR arrives 20 bx early → misalign_count +1, bxid not reloaded; 2 more bad orbits → UNLOCKED; next BCR sets bxid=0 and enters ACQUIRE.
- ded_count preloaded to 0xFFFF by repeated errors, then clear_counters asserted on the same cycle as a DED → ded_count=0 next cycle; further DEDs saturate at 0xFFFF.
